// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one 1-bit step per clock on a work register,
// with a START/BUSY/DONE handshake. RESULT/CARRY/DONE register on the edge leaving FIN.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [7:0]       AMOUNT,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FIN} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cy_q, cy_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   eff_n;

    // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH.
    always_comb begin
        if (op_t'(OPCODE) == OP_ROR) begin
            eff_n = CNT_W'(32'(AMOUNT) % WIDTH);
        end else if (32'(AMOUNT) >= WIDTH) begin
            eff_n = CNT_W'(WIDTH);
        end else begin
            eff_n = CNT_W'(AMOUNT);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = op_t'(OPCODE);
                    work_d  = DATA_IN;
                    cnt_d   = eff_n;
                    cy_d    = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q != '0) ? S_SHIFT : S_FIN;
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL: begin
                        cy_d   = work_q[WIDTH-1];
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        cy_d   = work_q[0];
                        work_d = {1'b0, work_q[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        cy_d   = work_q[0];
                        work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                    end
                    default: begin
                        cy_d   = work_q[0];
                        work_d = {work_q[0], work_q[WIDTH-1:1]};
                    end
                endcase
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                result_d = work_q;
                carry_d  = cy_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_SHIFT);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            work_q   <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign CARRY  = carry_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus random operations
// checked against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int W = 8;

    logic         CLK;
    logic         RESET;
    logic         START;
    logic [1:0]   OPCODE;
    logic [W-1:0] DATA_IN;
    logic [7:0]   AMOUNT;
    logic [W-1:0] RESULT;
    logic         CARRY;
    logic         BUSY;
    logic         DONE;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] prev_res = '0;
    logic         prev_cy  = 1'b0;

    shift_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
        .DATA_IN(DATA_IN), .AMOUNT(AMOUNT), .RESULT(RESULT),
        .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int eff_count(input logic [1:0] op, input logic [7:0] amt);
        if (op == 2'b11) return int'(amt) % W;
        return (int'(amt) > W) ? W : int'(amt);
    endfunction

    // Whole-operation model: shift by n in one go, carry is the last bit to leave.
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                         input logic [7:0] amt);
        int n;
        logic [2*W-1:0] wide;
        logic [W-1:0] r;
        logic c;
        n = eff_count(op, amt);
        c = (n == 0) ? 1'b0 : d[n-1];
        case (op)
            2'b00: begin
                wide = {{W{1'b0}}, d} << n;
                r = wide[W-1:0];
                c = (n == 0) ? 1'b0 : wide[W];
            end
            2'b01: r = d >> n;
            2'b10: r = $signed(d) >>> n;
            default: r = (d >> n) | (d << (W - n));
        endcase
        return {c, r};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                          input logic [7:0] amt);
        logic [W:0] exp;
        int n, busy_cnt, lat;
        exp = model(op, d, amt);
        n = eff_count(op, amt);
        @(negedge CLK);
        START = 1'b1; OPCODE = op; DATA_IN = d; AMOUNT = amt;
        tick();
        START = 1'b0;
        OPCODE = 2'($urandom); DATA_IN = W'($urandom); AMOUNT = 8'($urandom);
        chk({tag, "_hold"}, {RESULT, CARRY}, {prev_res, prev_cy});
        busy_cnt = BUSY ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (DONE) begin
                lat = k;
                break;
            end
            if (BUSY) busy_cnt++;
        end
        if (lat == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_lat"}, lat, n + 2);
        chk({tag, "_busy"}, busy_cnt, n + 1);
        chk({tag, "_res"}, RESULT, exp[W-1:0]);
        chk({tag, "_cy"}, CARRY, exp[W]);
        tick();
        chk({tag, "_pulse"}, DONE, 0);
        prev_res = exp[W-1:0];
        prev_cy  = exp[W];
    endtask

    initial begin
        int dn, last, cnt;
        logic pd;
        RESET = 1'b0; START = 1'b0; OPCODE = '0; DATA_IN = '0; AMOUNT = '0;
        repeat (3) @(negedge CLK);
        chk("rst_res", RESULT, 0);
        chk("rst_cy", CARRY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        RESET = 1'b1;

        run_op("t1_sll", 2'b00, 8'h81, 8'd1);
        run_op("t2_sra3", 2'b10, 8'h80, 8'd3);
        chk("t2_sra3_val", RESULT, 8'hF0);
        run_op("t2_sra200", 2'b10, 8'h80, 8'd200);
        chk("t2_sra200_val", {RESULT, CARRY}, {8'hFF, 1'b1});
        run_op("t2_srl3", 2'b01, 8'h80, 8'd3);
        chk("t2_srl3_val", RESULT, 8'h10);
        run_op("t3_ror9", 2'b11, 8'h01, 8'd9);
        chk("t3_ror9_val", {RESULT, CARRY}, {8'h80, 1'b1});
        run_op("t3_ror8", 2'b11, 8'h5A, 8'd8);
        chk("t3_ror8_val", {RESULT, CARRY}, {8'h5A, 1'b0});
        run_op("sll8", 2'b00, 8'h01, 8'd8);
        chk("sll8_val", {RESULT, CARRY}, {8'h00, 1'b1});

        // START pulses during SHIFT and FIN must be ignored.
        @(negedge CLK);
        START = 1'b1; OPCODE = 2'b01; DATA_IN = 8'hFF; AMOUNT = 8'd5;
        tick();
        START = 1'b0; OPCODE = 2'b00; DATA_IN = 8'h01; AMOUNT = 8'd1;
        tick();
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("t4_busy_mid", BUSY, 1);
        repeat (3) tick();
        chk("t4_fin_busy", BUSY, 0);
        chk("t4_fin_done", DONE, 0);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("t4_done", DONE, 1);
        chk("t4_res", {RESULT, CARRY}, {8'h07, 1'b1});
        tick();
        chk("t4_ign_done", DONE, 0);
        chk("t4_ign_busy", BUSY, 0);
        prev_res = 8'h07; prev_cy = 1'b1;
        run_op("t4_next", 2'b00, 8'h01, 8'd1);

        // Asynchronous reset mid-SHIFT.
        @(negedge CLK);
        START = 1'b1; OPCODE = 2'b00; DATA_IN = 8'h0F; AMOUNT = 8'd7;
        tick();
        START = 1'b0;
        tick();
        tick();
        #3 RESET = 1'b0;
        #1;
        chk("t5_busy", BUSY, 0);
        chk("t5_done", DONE, 0);
        chk("t5_res", RESULT, 0);
        chk("t5_cy", CARRY, 0);
        @(negedge CLK);
        RESET = 1'b1;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (DONE || BUSY) dn++;
        end
        chk("t5_quiet", dn, 0);
        prev_res = '0; prev_cy = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 10));
            run_op("rnd", 2'($urandom), W'($urandom), a);
        end

        // Back-to-back with START held high.
        @(negedge CLK);
        START = 1'b1; OPCODE = 2'b01; DATA_IN = 8'h40; AMOUNT = 8'd2;
        last = -1; cnt = 0; pd = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (DONE) begin
                cnt++;
                chk("t6_res", RESULT, 8'h10);
                chk("t6_consec", pd, 0);
                if (last >= 0) chk("t6_period", k - last, 5);
                last = k;
            end
            pd = DONE;
        end
        chk("t6_count", cnt >= 5, 1);
        START = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
